// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with built-in load-use hazard detection.
// Inserts a one-cycle bubble on a load-use dependency, squashes on flush, counts bubbles.
module id_ex_reg #(
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic [8:0]    id_ctrl,
    input  logic [DW-1:0] id_pc4,
    input  logic [DW-1:0] id_rd1,
    input  logic [DW-1:0] id_rd2,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_rs,
    input  logic [4:0]    id_rt,
    input  logic [4:0]    id_rd,
    input  logic          id_uses_rt,
    output logic [8:0]    ex_ctrl,
    output logic [DW-1:0] ex_pc4,
    output logic [DW-1:0] ex_rd1,
    output logic [DW-1:0] ex_rd2,
    output logic [DW-1:0] ex_imm,
    output logic [4:0]    ex_rs,
    output logic [4:0]    ex_rt,
    output logic [4:0]    ex_rd,
    output logic          ex_valid,
    output logic          stall,
    output logic [CW-1:0] bubble_cnt
);

    localparam int MEMREAD_BIT = 6;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [8:0]    ctrl_reg;
    logic [DW-1:0] pc4_reg;
    logic [DW-1:0] rd1_reg;
    logic [DW-1:0] rd2_reg;
    logic [DW-1:0] imm_reg;
    logic [4:0]    rs_reg;
    logic [4:0]    rt_reg;
    logic [4:0]    rd_reg;
    logic          valid_reg;
    logic [CW-1:0] cnt_reg;

    logic          rs_match;
    logic          rt_match;
    logic          hazard;
    logic          bubble;
    logic          count_en;

    // Hazard looks only at registered EX state and ID inputs; $0 never creates a dependency.
    always_comb begin
        rs_match = (rt_reg == id_rs);
        rt_match = id_uses_rt && (rt_reg == id_rt);
        hazard   = valid_reg && ctrl_reg[MEMREAD_BIT] && (rt_reg != 5'd0)
                   && (rs_match || rt_match);
        bubble   = flush || hazard;
        count_en = !flush && hazard && (cnt_reg != CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_reg  <= '0;
            pc4_reg   <= '0;
            rd1_reg   <= '0;
            rd2_reg   <= '0;
            imm_reg   <= '0;
            rs_reg    <= '0;
            rt_reg    <= '0;
            rd_reg    <= '0;
            valid_reg <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            // Data and specifiers always follow ID; only control and valid are killed by a bubble.
            pc4_reg   <= id_pc4;
            rd1_reg   <= id_rd1;
            rd2_reg   <= id_rd2;
            imm_reg   <= id_imm;
            rs_reg    <= id_rs;
            rt_reg    <= id_rt;
            rd_reg    <= id_rd;
            ctrl_reg  <= bubble ? 9'd0 : id_ctrl;
            valid_reg <= !bubble;
            if (count_en) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign ex_ctrl    = ctrl_reg;
    assign ex_pc4     = pc4_reg;
    assign ex_rd1     = rd1_reg;
    assign ex_rd2     = rd2_reg;
    assign ex_imm     = imm_reg;
    assign ex_rs      = rs_reg;
    assign ex_rt      = rt_reg;
    assign ex_rd      = rd_reg;
    assign ex_valid   = valid_reg;
    assign stall      = hazard;
    assign bubble_cnt = cnt_reg;

endmodule

// File: tb/tb_id_ex_reg.sv
// Self-checking bench for id_ex_reg: a reference model pushes the expected EX state per edge,
// which is popped and compared after the edge.
module tb_id_ex_reg;

    localparam int DW = 32;
    localparam int CW = 2;

    localparam logic [8:0] LW_CTRL  = 9'h1C8;
    localparam logic [8:0] ADD_CTRL = 9'h106;
    localparam logic [8:0] SW_CTRL  = 9'h028;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic [8:0]    id_ctrl;
    logic [DW-1:0] id_pc4, id_rd1, id_rd2, id_imm;
    logic [4:0]    id_rs, id_rt, id_rd;
    logic          id_uses_rt;
    logic [8:0]    ex_ctrl;
    logic [DW-1:0] ex_pc4, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]    ex_rs, ex_rt, ex_rd;
    logic          ex_valid;
    logic          stall;
    logic [CW-1:0] bubble_cnt;

    typedef struct packed {
        logic [8:0]    ctrl;
        logic [DW-1:0] pc4;
        logic [DW-1:0] rd1;
        logic [DW-1:0] rd2;
        logic [DW-1:0] imm;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    rd;
        logic          valid;
        logic [CW-1:0] cnt;
    } snap_t;

    snap_t exp_q[$];
    snap_t model;
    snap_t exp_snap;
    snap_t obs_snap;
    logic  model_stall;
    int    errors = 0;
    int    checks = 0;

    id_ex_reg #(.DW(DW), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .id_ctrl    (id_ctrl),
        .id_pc4     (id_pc4),
        .id_rd1     (id_rd1),
        .id_rd2     (id_rd2),
        .id_imm     (id_imm),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .id_uses_rt (id_uses_rt),
        .ex_ctrl    (ex_ctrl),
        .ex_pc4     (ex_pc4),
        .ex_rd1     (ex_rd1),
        .ex_rd2     (ex_rd2),
        .ex_imm     (ex_imm),
        .ex_rs      (ex_rs),
        .ex_rt      (ex_rt),
        .ex_rd      (ex_rd),
        .ex_valid   (ex_valid),
        .stall      (stall),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    assign obs_snap = '{ctrl: ex_ctrl, pc4: ex_pc4, rd1: ex_rd1, rd2: ex_rd2, imm: ex_imm,
                        rs: ex_rs, rt: ex_rt, rd: ex_rd, valid: ex_valid, cnt: bubble_cnt};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // Drive one ID instruction at the falling edge and push the model's next EX state.
    task automatic drive(input logic rst, input logic fl, input logic [8:0] ctrl,
                         input logic [DW-1:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic uses_rt);
        snap_t nxt;
        @(negedge clk);
        reset      = rst;
        flush      = fl;
        id_ctrl    = ctrl;
        id_pc4     = $urandom;
        id_rd1     = $urandom;
        id_rd2     = $urandom;
        id_imm     = imm;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_uses_rt = uses_rt;
        model_stall = model.valid && model.ctrl[6] && (model.rt != 5'd0)
                      && ((model.rt == rs) || (uses_rt && (model.rt == rt)));
        if (rst) begin
            nxt = '0;
        end else begin
            nxt = model;
            nxt.pc4 = id_pc4;
            nxt.rd1 = id_rd1;
            nxt.rd2 = id_rd2;
            nxt.imm = imm;
            nxt.rs  = rs;
            nxt.rt  = rt;
            nxt.rd  = rd;
            if (fl || model_stall) begin
                nxt.ctrl  = 9'd0;
                nxt.valid = 1'b0;
                if (!fl && model.cnt != {CW{1'b1}}) nxt.cnt = model.cnt + 1'b1;
            end else begin
                nxt.ctrl  = ctrl;
                nxt.valid = 1'b1;
            end
        end
        model = nxt;
        exp_q.push_back(nxt);
        #1;
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        exp_snap = exp_q.pop_front();
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b1, 9'h1FF, 32'hFFFF_FFFF, 5'd31, 5'd31, 5'd31, 1'b1);
        advance();
        checks++;
        if (obs_snap !== exp_snap) begin
            errors++;
            $display("FAIL reset_state: got %h required %h", obs_snap, exp_snap);
        end
        reset = 1'b0;
        flush = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: got %b required 0", stall);
        end
        $display("reset: ex=%h stall=%b", obs_snap, stall);
    endtask

    task automatic test_normal();
        drive(1'b0, 1'b0, 9'h1A3, 32'hFFFF_FFF8, 5'd3, 5'd4, 5'd5, 1'b1);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL normal_stall: got %b required 0", stall);
        end
        advance();
        checks++;
        if (obs_snap !== exp_snap) begin
            errors++;
            $display("FAIL normal_capture: got %h required %h", obs_snap, exp_snap);
        end
        checks++;
        if (ex_ctrl !== 9'h1A3 || ex_imm !== 32'hFFFF_FFF8 || ex_valid !== 1'b1) begin
            errors++;
            $display("FAIL normal_fields: got ctrl=%h imm=%h valid=%b required 1a3 fffffff8 1",
                     ex_ctrl, ex_imm, ex_valid);
        end
        $display("normal: ctrl=%h imm=%h valid=%b", ex_ctrl, ex_imm, ex_valid);
    endtask

    task automatic test_load_use();
        drive(1'b0, 1'b0, LW_CTRL, 32'd16, 5'd2, 5'd8, 5'd0, 1'b0);
        advance();
        drive(1'b0, 1'b0, ADD_CTRL, 32'd0, 5'd8, 5'd9, 5'd10, 1'b1);
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL load_use_stall: got %b required 1", stall);
        end
        advance();
        checks++;
        if (obs_snap !== exp_snap || ex_valid !== 1'b0 || ex_ctrl !== 9'd0 || bubble_cnt !== 2'd1) begin
            errors++;
            $display("FAIL load_use_bubble: got %h required %h (cnt=%0d, need 1)", obs_snap, exp_snap, bubble_cnt);
        end
        drive(1'b0, 1'b0, ADD_CTRL, 32'd0, 5'd8, 5'd9, 5'd10, 1'b1);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL load_use_release: got %b required 0", stall);
        end
        advance();
        checks++;
        if (obs_snap !== exp_snap || ex_valid !== 1'b1 || ex_ctrl !== ADD_CTRL) begin
            errors++;
            $display("FAIL load_use_capture: got %h required %h", obs_snap, exp_snap);
        end
        $display("load_use: ctrl=%h valid=%b cnt=%0d", ex_ctrl, ex_valid, bubble_cnt);
    endtask

    task automatic test_rt_zero();
        drive(1'b0, 1'b0, LW_CTRL, 32'd4, 5'd2, 5'd8, 5'd0, 1'b0);
        advance();
        drive(1'b0, 1'b0, ADD_CTRL, 32'd0, 5'd3, 5'd8, 5'd11, 1'b0);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL rt_unused: got %b required 0", stall);
        end
        advance();
        drive(1'b0, 1'b0, LW_CTRL, 32'd4, 5'd2, 5'd0, 5'd0, 1'b0);
        advance();
        drive(1'b0, 1'b0, ADD_CTRL, 32'd0, 5'd0, 5'd0, 5'd12, 1'b1);
        checks++;
        if (stall !== 1'b0) begin
            errors++;
            $display("FAIL zero_reg: got %b required 0", stall);
        end
        advance();
        drive(1'b0, 1'b0, LW_CTRL, 32'd8, 5'd2, 5'd8, 5'd0, 1'b0);
        advance();
        drive(1'b0, 1'b0, SW_CTRL, 32'd12, 5'd2, 5'd8, 5'd0, 1'b1);
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL store_after_load: got %b required 1", stall);
        end
        advance();
        checks++;
        if (obs_snap !== exp_snap) begin
            errors++;
            $display("FAIL rt_zero_state: got %h required %h", obs_snap, exp_snap);
        end
        $display("rt_zero: ctrl=%h valid=%b cnt=%0d", ex_ctrl, ex_valid, bubble_cnt);
    endtask

    task automatic test_flush_stall();
        logic [CW-1:0] cnt_before;
        drive(1'b0, 1'b0, LW_CTRL, 32'd0, 5'd2, 5'd8, 5'd0, 1'b0);
        advance();
        cnt_before = model.cnt;
        drive(1'b0, 1'b1, ADD_CTRL, 32'd0, 5'd8, 5'd9, 5'd10, 1'b1);
        checks++;
        if (stall !== 1'b1) begin
            errors++;
            $display("FAIL flush_stall_out: got %b required 1", stall);
        end
        advance();
        checks++;
        if (obs_snap !== exp_snap || ex_valid !== 1'b0 || ex_ctrl !== 9'd0 || bubble_cnt !== cnt_before) begin
            errors++;
            $display("FAIL flush_stall_state: got %h required %h (cnt=%0d, need %0d)",
                     obs_snap, exp_snap, bubble_cnt, cnt_before);
        end
        drive(1'b0, 1'b1, ADD_CTRL, 32'd0, 5'd1, 5'd2, 5'd3, 1'b1);
        advance();
        checks++;
        if (obs_snap !== exp_snap || ex_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_only: got %h required %h", obs_snap, exp_snap);
        end
        $display("flush_stall: valid=%b cnt=%0d", ex_valid, bubble_cnt);
    endtask

    task automatic test_reset_mid();
        drive(1'b0, 1'b0, LW_CTRL, 32'd0, 5'd2, 5'd8, 5'd0, 1'b0);
        advance();
        drive(1'b1, 1'b1, ADD_CTRL, 32'hDEAD_BEEF, 5'd8, 5'd8, 5'd10, 1'b1);
        advance();
        checks++;
        if (obs_snap !== '0 || obs_snap !== exp_snap) begin
            errors++;
            $display("FAIL reset_mid: got %h required 0", obs_snap);
        end
        $display("reset_mid: ex=%h", obs_snap);
    endtask

    task automatic test_saturation();
        logic [CW-1:0] want [4];
        want[0] = 2'd1; want[1] = 2'd2; want[2] = 2'd3; want[3] = 2'd3;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, LW_CTRL, 32'd0, 5'd2, 5'd8, 5'd0, 1'b0);
            advance();
            drive(1'b0, 1'b0, ADD_CTRL, 32'd0, 5'd8, 5'd9, 5'd10, 1'b1);
            advance();
            checks++;
            if (bubble_cnt !== want[i] || obs_snap !== exp_snap) begin
                errors++;
                $display("FAIL saturation_%0d: got cnt=%0d required %0d (ex=%h need %h)",
                         i, bubble_cnt, want[i], obs_snap, exp_snap);
            end
            $display("saturation %0d: cnt=%0d", i, bubble_cnt);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 9'($urandom), $urandom,
                  5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)), 5'($urandom), 1'($urandom));
            checks++;
            if (stall !== model_stall) begin
                errors++;
                $display("FAIL b2b_stall_%0d: got %b required %b", i, stall, model_stall);
            end
            advance();
            checks++;
            if (obs_snap !== exp_snap) begin
                errors++;
                $display("FAIL b2b_state_%0d: got %h required %h", i, obs_snap, exp_snap);
            end
            $display("b2b %0d: ctrl=%h valid=%b cnt=%0d", i, ex_ctrl, ex_valid, bubble_cnt);
        end
    endtask

    initial begin
        model = '0;
        model_stall = 1'b0;
        reset = 1'b1;
        flush = 1'b0;
        id_ctrl = '0; id_pc4 = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
        id_rs = '0; id_rt = '0; id_rd = '0; id_uses_rt = 1'b0;
        test_reset();
        test_normal();
        test_load_use();
        test_rt_zero();
        test_flush_stall();
        test_reset_mid();
        test_saturation();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_reg.md
# id_ex_reg

ID/EX pipeline register for the five-stage MIPS datapath, with the load-use hazard detector built in. Captures decoded control, register-file read data, the extended immediate (output of the ID-stage sign/zero extender) and register specifiers each cycle. Inserts a bubble and stalls PC and IF/ID on a load-use dependency. Squashes the ID instruction on a taken-branch flush and counts inserted bubbles.

## Interface
- DW, 32, datapath width (read data, immediate, PC+4)
- CW, 16, bubble-counter width

- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; clears every register
- flush  in  1  taken branch/jump: squash the ID instruction
- id_ctrl  in  9  {RegWrite, MemtoReg, MemRead, MemWrite, Branch, ALUSrc, RegDst, ALUOp[1:0]}
- id_pc4  in  DW  PC+4 of ID instruction
- id_rd1, id_rd2  in  DW  register-file read data
- id_imm  in  DW  extended immediate
- id_rs, id_rt, id_rd  in  5  register specifiers
- id_uses_rt  in  1  ID instruction reads rt as a source (R-type, beq/bne, sw)
- ex_ctrl  out  9  registered control, same packing as id_ctrl
- ex_pc4, ex_rd1, ex_rd2, ex_imm  out  DW  registered data
- ex_rs, ex_rt, ex_rd  out  5  registered specifiers
- ex_valid  out  1  EX holds a real instruction
- stall  out  1  combinational: load-use hazard; PCWrite = IFIDWrite = ~stall
- bubble_cnt  out  CW  saturating count of hazard bubbles

## Operation
- Hazard, combinational from current EX state and ID inputs: stall = ex_valid & ex_ctrl.MemRead & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt))).
- Per-edge priority: reset > flush > stall > normal capture.
- reset: all outputs registered to 0 (ex_ctrl=0, data=0, specifiers=0, ex_valid=0, bubble_cnt=0).
- flush: ex_ctrl←0, ex_valid←0; data/specifier fields capture ID inputs as normal. stall output still computed but no bubble counted.
- stall (no flush): ex_ctrl←0, ex_valid←0, data/specifier fields capture ID inputs; bubble_cnt←bubble_cnt+1 unless all-ones (saturate, no wrap).
- normal: all fields ←ID inputs, ex_valid←1.
- The bubble written on stall has ex_valid=0, so stall deasserts on the next cycle; a load-use stall is exactly one cycle.
- No hazard on $0: ex_rt==0 never stalls.
- Store after load: sw with id_uses_rt=1 and rt matching the load destination stalls. Forwarding is not handled here.

## Timing
- Latency: ID inputs appear on ex_* one clock after the edge that samples them.
- stall is valid in the same cycle as the ID inputs and EX state that cause it. It depends only on registered EX fields and ID inputs, with no combinational path through flush or reset.
- Reset mid-stream: the next edge clears everything regardless of flush/stall. stall reads 0 in the cycle after reset, because ex_valid=0.
- Simultaneous flush and stall: the flush bubble wins. bubble_cnt is unchanged. The stall output remains asserted that cycle; upstream treats flush as dominant.
- bubble_cnt at 2^CW−1 holds on further stalls.

## Test plan
- Reset: drive all inputs nonzero, assert reset one edge -> every output 0, stall=0.
- Normal capture: id_ctrl=9'h1A3, id_imm=32'hFFFF_FFF8, id_rs=3, id_rt=4, id_rd=5, no flush -> next cycle ex_ctrl=9'h1A3, ex_imm=32'hFFFF_FFF8, ex_valid=1, stall=0.
- Load-use: EX holds lw with MemRead=1, ex_rt=8; ID add with id_rs=8 -> stall=1. Next edge: ex_ctrl=0, ex_valid=0, bubble_cnt=1. Following cycle, same ID inputs -> stall=0, add captured with ex_valid=1.
- rt/$0 cases: EX lw with ex_rt=8 and ID id_rt=8, id_uses_rt=0 -> stall=0. EX lw with ex_rt=0 and id_rs=0 -> stall=0.
- Flush+stall: load-use condition with flush=1 -> ex_valid=0, ex_ctrl=0, bubble_cnt unchanged.
- Saturation: CW=2, force four load-use stalls -> bubble_cnt sequence 1,2,3,3.
